// File: rtl/cube_root_pkg.sv
// Shared types and helpers for the iterative cube-root block.
package cube_root_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width for a given radicand width: ceil(width/3).
  function automatic int root_width(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/cube_root_tick.sv
// Prescaler for slow-step mode: pulses tick every PRESCALE enabled clocks.
module cube_root_tick #(
  parameter int PRESCALE = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cube_root_iter.sv
// Iterative floor cube root, one root bit per step (binary digit-by-digit).
// Define CUBE_ROOT_STEP_EN to slow each step down to one per PRESCALE clocks.
module cube_root_iter
  import cube_root_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int PRESCALE = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [root_width(WIDTH)-1:0]  out_root,
  output logic [WIDTH-1:0]              out_rem,
  output logic                          busy
);

  localparam int RW = root_width(WIDTH);
  localparam int XW = WIDTH + 3;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;

  if (WIDTH < 3 || WIDTH > 48 || PRESCALE < 2 || PRESCALE > 65536) begin : g_bad_param
    $error("cube_root_iter: WIDTH or PRESCALE out of range");
  end

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q;
  logic [RW-1:0]   y_q;
  logic [IW-1:0]   idx_q;
  logic            accept;
  logic            step;

  logic [XW-1:0]   y2, b, x_sh, x_n;
  logic [RW-1:0]   y_n;
  logic [6:0]      shamt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign accept    = in_valid && in_ready;

`ifdef CUBE_ROOT_STEP_EN
  cube_root_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (state_q == CALC),
    .tick  (step)
  );
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (step && idx_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One recurrence step: double y, then try to take b = 3y(y+1)+1 at digit idx.
  always_comb begin
    shamt = 7'(idx_q) * 7'd3;
    y2    = XW'(y_q) << 1;
    b     = y2 * (y2 + XW'(1)) * XW'(3) + XW'(1);
    x_sh  = x_q >> shamt;
    x_n   = x_q;
    y_n   = y2[RW-1:0];
    if (x_sh >= b) begin
      x_n = x_q - (b << shamt);
      y_n = y2[RW-1:0] + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      out_root <= '0;
      out_rem  <= '0;
    end else if (accept) begin
      x_q   <= XW'(in_value);
      y_q   <= '0;
      idx_q <= IW'(RW - 1);
    end else if (state_q == CALC && step) begin
      x_q   <= x_n;
      y_q   <= y_n;
      idx_q <= idx_q - IW'(1);
      if (idx_q == '0) begin
        out_root <= y_n;
        out_rem  <= x_n[WIDTH-1:0];
      end
    end
  end

endmodule
